// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// FSM states and small op-decode helpers used by the datapath.
package mult_div_unit_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_FIX  = 2'b10
   } mdu_state_e;

   // op[1] selects divide, op[0] selects the unsigned variant
   function automatic logic op_is_div(input logic [1:0] op_code);
      return op_code[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op_code);
      return ~op_code[0];
   endfunction

endpackage

// File: rtl/mult_div_unit_cneg.sv
// Conditional two's-complement: out = neg ? -in : in.
// Used for operand magnitudes and for the sign fix-up of results.
module mdu_cneg #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   assign out = neg ? -in : in;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with private HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division on operand
// magnitudes; the sign is restored in a final FIX cycle.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit FAST_ZERO = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   mdu_state_e         state, state_nxt;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;       // {upper, lower}: product, or {remainder, quotient}
   logic [WIDTH-1:0]   opb;       // captured |b|
   logic               op_div;
   logic               neg_res;   // negate product / quotient
   logic               neg_rem;   // negate remainder (dividend sign)

   // Operand decode at the start edge
   logic             sgn_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic             accept, dz, fz;

   assign sgn_op = op_is_signed(op);
   assign a_neg  = sgn_op & a[WIDTH-1];
   assign b_neg  = sgn_op & b[WIDTH-1];
   assign accept = (state == ST_IDLE) & start;
   assign dz     = accept & op_is_div(op) & (b == '0);
   assign fz     = FAST_ZERO & accept & ~dz & ((a == '0) | (b == '0));

   mdu_cneg #(.WIDTH(WIDTH)) u_abs_a (.neg(a_neg), .in(a), .out(a_abs));
   mdu_cneg #(.WIDTH(WIDTH)) u_abs_b (.neg(b_neg), .in(b), .out(b_abs));

   // One iteration step for either operation
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic               div_ok;
   logic [2*WIDTH-1:0] acc_step;

   assign mul_addend = acc[0] ? opb : '0;
   assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
   assign div_trial  = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opb};
   assign div_ok     = ~div_trial[WIDTH];
   assign acc_step   = op_div
                     ? (div_ok ? {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                               : {acc[2*WIDTH-2:0], 1'b0})
                     : {mul_sum, acc[WIDTH-1:1]};

   // Sign fix-up of the final result
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   mdu_cneg #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_res), .in(acc), .out(prod_fix));
   mdu_cneg #(.WIDTH(WIDTH)) u_fix_quot (.neg(neg_res), .in(acc[WIDTH-1:0]), .out(quot_fix));
   mdu_cneg #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_rem), .in(acc[2*WIDTH-1:WIDTH]), .out(rem_fix));

   assign busy = (state != ST_IDLE);

   // FSM state register
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // FSM next-state: divide-by-zero stays in IDLE, zero operands may skip RUN
   // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (accept && !dz) state_nxt = fz ? ST_FIX : ST_RUN;
         ST_RUN:  if (count == CNT_W'(1)) state_nxt = ST_FIX;
         ST_FIX:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, result write and HI/LO moves
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count    <= '0;
         acc      <= '0;
         opb      <= '0;
         op_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (wr_hi) hi <= wr_data;
               if (wr_lo) lo <= wr_data;
               if (start) begin
                  if (dz) begin
                     done     <= 1'b1;
                     div_zero <= 1'b1;
                  end else begin
                     op_div  <= op_is_div(op);
                     neg_res <= a_neg ^ b_neg;
                     neg_rem <= a_neg;
                     opb     <= b_abs;
                     count   <= CNT_W'(WIDTH);
                     acc     <= fz ? '0 : {{WIDTH{1'b0}}, a_abs};
                  end
               end
            end
            ST_RUN: begin
               acc   <= acc_step;
               count <= count - CNT_W'(1);
            end
            ST_FIX: begin
               if (op_div) begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
// A second instance with FAST_ZERO=0 checks full-length zero-operand timing.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        start_s = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic        wr_hi = 1'b0, wr_lo = 1'b0;
   logic [31:0] wr_data = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;
   logic        busy_s, done_s, div_zero_s;
   logic [31:0] hi_s, lo_s;

   int checks = 0;
   int errors = 0;

   mult_div_unit #(.WIDTH(32), .FAST_ZERO(1'b1)) u_dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   mult_div_unit #(.WIDTH(32), .FAST_ZERO(1'b0)) u_slow (
      .clock(clock), .reset(reset), .start(start_s), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
      .busy(busy_s), .done(done_s), .div_zero(div_zero_s), .hi(hi_s), .lo(lo_s)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for done; counts edges and cycles with busy high
   task automatic wait_done(output int edges, output int busy_cycles);
      edges = 0;
      busy_cycles = 0;
      while (!done && edges < 100) begin
         if (busy) busy_cycles++;
         @(posedge clock); #1;
         edges++;
      end
   endtask

   // Issue one op; E0 is the first edge; a/b are scrambled after E0
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int edges, output int busy_cycles);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      a = 32'hA5A5_A5A5;
      b = 32'h5A5A_5A5A;
      wait_done(edges, busy_cycles);
   endtask

   int  e, bc;
   logic seen;

   initial begin
      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz", div_zero, 0);
      check("rst_hilo", {hi, lo}, 64'h0);
      reset = 1'b1;
      @(posedge clock); #1;

      // MULT -3 * 7, with latency and single-cycle done
      do_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, e, bc);
      check("mult_edges", e, 33);
      check("mult_busy_cycles", bc, 33);
      check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      check("mult_busy_at_done", busy, 0);
      @(posedge clock); #1;
      check("mult_done_pulse", done, 0);

      do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc);
      check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      do_op(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc);
      check("mult_m1m1_hilo", {hi, lo}, 64'h0000_0000_0000_0001);

      // Divides
      do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, e, bc);
      check("div_edges", e, 33);
      check("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(MDU_DIV, 32'd7, 32'hFFFF_FFFE, e, bc);
      check("div_7_m2", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
      do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, e, bc);
      check("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
      check("div_min_m1_dz", div_zero, 0);
      do_op(MDU_DIVU, 32'd100, 32'd7, e, bc);
      check("divu_100_7", {hi, lo}, 64'h0000_0002_0000_000E);

      // MTHI / MTLO then divide-by-zero
      wr_hi = 1'b1; wr_data = 32'h1234;
      @(posedge clock); #1;
      wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h5678;
      @(posedge clock); #1;
      wr_lo = 1'b0;
      check("mt_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
      do_op(MDU_DIVU, 32'd5, 32'd0, e, bc);
      check("dz_edges", e, 0);
      check("dz_flag", div_zero, 1);
      check("dz_busy_cycles", bc, 0);
      check("dz_hilo", {hi, lo}, 64'h0000_1234_0000_5678);
      @(posedge clock); #1;
      check("dz_pulse", {done, div_zero, busy}, 3'b000);
      wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hCAFE_F00D;
      @(posedge clock); #1;
      wr_hi = 1'b0; wr_lo = 1'b0;
      check("mt_both", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);

      // Reset in the middle of a MULT
      op = MDU_MULT; a = 32'd9; b = 32'd9; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_outs", {busy, done, div_zero}, 3'b000);
      check("midrst_hilo", {hi, lo}, 64'h0);
      @(posedge clock); #1;
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock); #1;
         if (done || busy) seen = 1'b1;
      end
      check("midrst_no_done", seen, 0);

      // start and wr_hi while busy are ignored
      op = MDU_MULTU; a = 32'd6; b = 32'd7; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      e = 0;
      repeat (5) begin
         @(posedge clock); #1;
         e++;
      end
      op = MDU_DIVU; a = 32'd100; b = 32'd0; start = 1'b1;
      wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
      @(posedge clock); #1;
      e++;
      start = 1'b0; wr_hi = 1'b0;
      check("ign_busy", busy, 1);
      while (!done && e < 100) begin
         @(posedge clock); #1;
         e++;
      end
      check("ign_edges", e, 33);
      check("ign_hilo", {hi, lo}, 64'h0000_0000_0000_002A);
      check("ign_dz", div_zero, 0);

      // New start issued in the done cycle
      do_op(MDU_MULTU, 32'd3, 32'd5, e, bc);
      check("b2b_edges", e, 33);
      check("b2b_hilo", {hi, lo}, 64'h0000_0000_0000_000F);

      // FAST_ZERO=1: zero operands finish after E1
      do_op(MDU_MULT, 32'd0, 32'd5, e, bc);
      check("fz_mult_edges", e, 1);
      check("fz_mult_busy", bc, 1);
      check("fz_mult_hilo", {hi, lo}, 64'h0);
      wr_lo = 1'b1; wr_data = 32'h77;
      @(posedge clock); #1;
      wr_lo = 1'b0;
      do_op(MDU_DIV, 32'd0, 32'd9, e, bc);
      check("fz_div_edges", e, 1);
      check("fz_div_hilo", {hi, lo}, 64'h0);

      // FAST_ZERO=0: same MULT takes the full iteration
      check("slow_hi_pre", hi_s, 64'hDEAD_BEEF);
      op = MDU_MULT; a = 32'd0; b = 32'd5; start_s = 1'b1;
      @(posedge clock); #1;
      start_s = 1'b0;
      e = 0;
      while (!done_s && e < 100) begin
         @(posedge clock); #1;
         e++;
      end
      check("slow_edges", e, 33);
      check("slow_hilo", {hi_s, lo_s}, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
